// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register.
//   state_e      : stage occupancy (EMPTY / FULL / SKID)
//   DefaultWidth : default data-path width
package pipe_pkg;

    localparam int unsigned DefaultWidth = 64;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StFull  = 2'd1,
        StSkid  = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_slot.sv
// Single data slot: WIDTH-bit register with synchronous reset and load enable.
//   clk   : clock
//   Reset : synchronous active-high reset, loads RESET_VAL
//   load  : capture d on the next posedge
//   d     : data in
//   q     : held data
module pipe_slot #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (Reset) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline stage register with a saturating stall counter.
//   clk, Reset          : clock and synchronous active-high reset
//   flush               : drop every held entry and any entry offered this cycle
//   in_valid/in_data    : upstream entry, accepted when in_ready=1
//   in_ready            : registered, low only when both slots are occupied
//   out_valid/out_data  : presented entry, always taken from the main slot
//   out_ready           : downstream accepts the presented entry
//   stall_cnt           : saturating count of cycles with out_valid=1, out_ready=0
module pipe_stage_reg import pipe_pkg::*; #(
    parameter int unsigned      WIDTH     = DefaultWidth,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int unsigned      CNT_W     = 16
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] stall_cnt
);

    state_e           state_q, state_d;
    logic             in_ready_q, out_valid_q;
    logic [CNT_W-1:0] stall_q;
    logic             in_fire, out_fire;
    logic             main_load, skid_load, main_from_skid;
    logic [WIDTH-1:0] main_q, skid_q, main_d;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    // Next state and slot load controls. Flush suppresses all loads so a
    // coincident input transfer is discarded.
    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        state_d   = StFull;
                        main_load = 1'b1;
                    end
                end
                StFull: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (out_fire) begin
                        state_d = StEmpty;
                    end else if (in_fire) begin
                        state_d   = StSkid;
                        skid_load = 1'b1;
                    end
                end
                StSkid: begin
                    if (out_fire) begin
                        state_d        = StFull;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    assign main_d = main_from_skid ? skid_q : in_data;

    // State plus handshake outputs, registered so in_ready never depends on out_ready.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q     <= StEmpty;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != StSkid);
            out_valid_q <= (state_d != StEmpty);
        end
    end

    // Stall counter survives flush; only Reset clears it.
    always_ff @(posedge clk) begin
        if (Reset) begin
            stall_q <= '0;
        end else if (out_valid_q && !out_ready && (stall_q != '1)) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    pipe_slot #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_main_slot (
        .clk   (clk),
        .Reset (Reset),
        .load  (main_load),
        .d     (main_d),
        .q     (main_q)
    );

    pipe_slot #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_skid_slot (
        .clk   (clk),
        .Reset (Reset),
        .load  (skid_load),
        .d     (in_data),
        .q     (skid_q)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vectors on a 64-bit instance with a
// non-zero reset value, counter saturation on a CNT_W=4 instance, and a
// randomised scoreboard run on 8-bit and 128-bit instances.
module tb_pipe_stage_reg;

    localparam logic [63:0] AResetVal = 64'h0000_0000_5A5A_0F0F;

    logic clk = 1'b0;
    logic Reset;
    always #5 clk = ~clk;

    // 64-bit directed instance
    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [63:0] a_in_data, a_out_data;
    logic [15:0] a_stall;

    // 8-bit instance, 4-bit counter
    logic       s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [7:0] s_in_data, s_out_data;
    logic [3:0] s_stall;

    // 128-bit instance
    logic         w_flush, w_in_valid, w_in_ready, w_out_valid, w_out_ready;
    logic [127:0] w_in_data, w_out_data;
    logic [15:0]  w_stall;

    pipe_stage_reg #(
        .WIDTH     (64),
        .RESET_VAL (AResetVal),
        .CNT_W     (16)
    ) dut_a (
        .clk       (clk),
        .Reset     (Reset),
        .flush     (a_flush),
        .in_valid  (a_in_valid),
        .in_data   (a_in_data),
        .in_ready  (a_in_ready),
        .out_valid (a_out_valid),
        .out_data  (a_out_data),
        .out_ready (a_out_ready),
        .stall_cnt (a_stall)
    );

    pipe_stage_reg #(
        .WIDTH     (8),
        .RESET_VAL (8'h00),
        .CNT_W     (4)
    ) dut_s (
        .clk       (clk),
        .Reset     (Reset),
        .flush     (s_flush),
        .in_valid  (s_in_valid),
        .in_data   (s_in_data),
        .in_ready  (s_in_ready),
        .out_valid (s_out_valid),
        .out_data  (s_out_data),
        .out_ready (s_out_ready),
        .stall_cnt (s_stall)
    );

    pipe_stage_reg #(
        .WIDTH     (128),
        .RESET_VAL ('0),
        .CNT_W     (16)
    ) dut_w (
        .clk       (clk),
        .Reset     (Reset),
        .flush     (w_flush),
        .in_valid  (w_in_valid),
        .in_data   (w_in_data),
        .in_ready  (w_in_ready),
        .out_valid (w_out_valid),
        .out_data  (w_out_data),
        .out_ready (w_out_ready),
        .stall_cnt (w_stall)
    );

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    logic [7:0]   q_s[$];
    logic [127:0] q_w[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        Reset       = 1'b1;
        a_flush     = 1'b0; a_in_valid = 1'b1; a_in_data = 64'hAAAA; a_out_ready = 1'b1;
        s_flush     = 1'b0; s_in_valid = 1'b0; s_in_data = '0;       s_out_ready = 1'b1;
        w_flush     = 1'b0; w_in_valid = 1'b0; w_in_data = '0;       w_out_ready = 1'b1;

        // Reset held two cycles with an entry offered.
        step();
        step();
        check("rst_out_valid", a_out_valid, 0);
        check("rst_out_data",  a_out_data,  AResetVal);
        check("rst_in_ready",  a_in_ready,  1);
        check("rst_stall",     a_stall,     0);
        Reset      = 1'b0;
        a_in_valid = 1'b0;

        // Streaming at full rate.
        a_out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 64'(i);
            step();
            check("stream_valid", a_out_valid, 1);
            check("stream_data",  a_out_data,  128'(i));
            check("stream_ready", a_in_ready,  1);
        end
        a_in_valid = 1'b0;
        step();
        check("stream_drain", a_out_valid, 0);
        check("stream_stall", a_stall,     0);

        // Backpressure into the skid slot.
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 64'h10;
        step();
        check("bp_full_data",  a_out_data, 64'h10);
        check("bp_full_ready", a_in_ready, 1);
        a_in_data = 64'h11;
        step();
        check("bp_skid_ready", a_in_ready, 0);
        check("bp_skid_stall", a_stall,    1);
        a_in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold_data", a_out_data, 64'h10);
        end
        check("bp_stall_4", a_stall, 4);
        a_out_ready = 1'b1;
        check("bp_first",  a_out_data, 64'h10);
        step();
        check("bp_second_valid", a_out_valid, 1);
        check("bp_second",       a_out_data,  64'h11);
        check("bp_ready_back",   a_in_ready,  1);
        step();
        check("bp_empty", a_out_valid, 0);
        check("bp_stall_kept", a_stall, 4);

        // Flush while SKID, with an entry offered at the same edge.
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 64'h20;
        step();
        a_in_data = 64'h21;
        step();
        check("fl_skid", a_in_ready, 0);
        a_flush   = 1'b1;
        a_in_data = 64'h22;
        step();
        check("fl_valid", a_out_valid, 0);
        check("fl_ready", a_in_ready,  1);
        check("fl_stall_not_cleared", a_stall, 6);
        a_flush     = 1'b0;
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("fl_nothing_emitted", a_out_valid, 0);
        end

        // Mid-operation reset discards the held entry.
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 64'h30;
        step();
        check("mr_full", a_out_valid, 1);
        Reset = 1'b1;
        step();
        Reset      = 1'b0;
        a_in_valid = 1'b0;
        check("mr_valid", a_out_valid, 0);
        check("mr_data",  a_out_data,  AResetVal);
        check("mr_stall", a_stall,     0);

        // Counter saturation on the CNT_W=4 instance.
        s_out_ready = 1'b0;
        s_in_valid  = 1'b1;
        s_in_data   = 8'h05;
        step();
        s_in_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 14) check("sat_14", s_stall, 14);
            if (i == 15) check("sat_15", s_stall, 15);
        end
        check("sat_hold", s_stall, 15);
        check("sat_data", s_out_data, 8'h05);

        // Randomised traffic with scoreboards on the 8-bit and 128-bit instances.
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            s_in_valid  = ($urandom_range(0, 3) != 0);
            s_in_data   = 8'($urandom);
            s_out_ready = ($urandom_range(0, 2) != 0);
            w_in_valid  = $urandom_range(0, 1) == 1;
            w_in_data   = {$urandom, $urandom, $urandom, $urandom};
            w_out_ready = ($urandom_range(0, 3) != 0);
            if (s_out_valid && s_out_ready) begin
                if (q_s.size() == 0) check("rnd8_unexpected", 1, 0);
                else check("rnd8_data", s_out_data, q_s.pop_front());
            end
            if (s_in_valid && s_in_ready) q_s.push_back(s_in_data);
            if (w_out_valid && w_out_ready) begin
                if (q_w.size() == 0) check("rnd128_unexpected", 1, 0);
                else check("rnd128_data", w_out_data, q_w.pop_front());
            end
            if (w_in_valid && w_in_ready) q_w.push_back(w_in_data);
            step();
        end
        // Drain: every remaining scoreboard entry must come out, then nothing more.
        s_in_valid  = 1'b0;
        w_in_valid  = 1'b0;
        s_out_ready = 1'b1;
        w_out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (s_out_valid) begin
                if (q_s.size() == 0) check("drain8_extra", 1, 0);
                else check("drain8_data", s_out_data, q_s.pop_front());
            end
            if (w_out_valid) begin
                if (q_w.size() == 0) check("drain128_extra", 1, 0);
                else check("drain128_data", w_out_data, q_w.pop_front());
            end
            step();
        end
        check("rnd8_lost",   q_s.size(), 0);
        check("rnd128_lost", q_w.size(), 0);
        check("rnd8_idle",   s_out_valid, 0);
        check("rnd128_idle", w_out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
